// File: rtl/reg_enc_pkg.sv
// Shared types and constants for the register mask encoder slice.
package reg_enc_pkg;

  localparam int REG_MASK_W = 32;
  localparam int REG_IDX_W  = 5;

  typedef enum logic {
    ENC_IDLE  = 1'b0,
    ENC_DRAIN = 1'b1
  } enc_state_t;

  typedef logic [REG_MASK_W-1:0] reg_mask_t;
  typedef logic [REG_IDX_W-1:0]  reg_idx_t;

endpackage

// File: rtl/encoder_32_to_5.sv
// Combinational 32-to-5 priority encoder; msb_first selects which end wins.
module encoder_32_to_5
  import reg_enc_pkg::*;
(
  input  reg_mask_t mask,
  input  logic      msb_first,
  output reg_idx_t  idx,
  output logic      any
);

  reg_idx_t lo_idx;
  reg_idx_t hi_idx;

  // Scan in both directions; the last hit in each loop is the winner
  always_comb begin
    lo_idx = '0;
    hi_idx = '0;
    for (int i = REG_MASK_W - 1; i >= 0; i--) begin
      if (mask[i]) lo_idx = reg_idx_t'(i);
    end
    for (int i = 0; i < REG_MASK_W; i++) begin
      if (mask[i]) hi_idx = reg_idx_t'(i);
    end
  end

  assign idx = msb_first ? hi_idx : lo_idx;
  assign any = |mask;

endmodule

// File: rtl/reg_mask_encoder.sv
// Sequential 32-to-5 mask encoder: drains a register mask one index per
// handshake. Build option REG_MASK_ENC_MSB_FIRST_EN drains highest index first.
module reg_mask_encoder
  import reg_enc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_MASK_W-1:0] mask_in,
  input  logic                 mask_valid,
  output logic                 mask_ready,
  output logic [REG_IDX_W-1:0] idx_out,
  output logic                 idx_valid,
  input  logic                 idx_ready,
  output logic                 idx_last,
  output logic [REG_IDX_W:0]   remaining
);

`ifdef REG_MASK_ENC_MSB_FIRST_EN
  localparam logic MSB_FIRST = 1'b1;
`else
  localparam logic MSB_FIRST = 1'b0;
`endif

  localparam logic [REG_IDX_W:0] REM_ONE = (REG_IDX_W + 1)'(1);

  enc_state_t          state;
  enc_state_t          state_nxt;
  reg_mask_t           pending;
  logic [REG_IDX_W:0]  rem_q;
  reg_idx_t            enc_idx;
  logic                enc_any;

  function automatic logic [REG_IDX_W:0] popcount(input reg_mask_t m);
    logic [REG_IDX_W:0] c;
    c = '0;
    for (int i = 0; i < REG_MASK_W; i++) begin
      c = c + {{REG_IDX_W{1'b0}}, m[i]};
    end
    return c;
  endfunction

  encoder_32_to_5 u_enc (
    .mask      (pending),
    .msb_first (MSB_FIRST),
    .idx       (enc_idx),
    .any       (enc_any)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ENC_IDLE;
    else        state <= state_nxt;
  end

  // Next state: empty masks never leave IDLE; the last handshake returns to IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      ENC_IDLE:  if (mask_valid && (|mask_in))      state_nxt = ENC_DRAIN;
      ENC_DRAIN: if (idx_ready && (rem_q == REM_ONE)) state_nxt = ENC_IDLE;
      default:   state_nxt = ENC_IDLE;
    endcase
  end

  // Outputs depend on registered state only
  always_comb begin
    mask_ready = (state == ENC_IDLE);
    idx_valid  = (state == ENC_DRAIN);
    idx_out    = (idx_valid && enc_any) ? enc_idx : '0;
    idx_last   = idx_valid && (rem_q == REM_ONE);
  end

  // Pending mask and count: load on accept, clear one bit per index handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      rem_q   <= '0;
    end else if (state == ENC_IDLE) begin
      if (mask_valid) begin
        pending <= mask_in;
        rem_q   <= popcount(mask_in);
      end
    end else if (idx_ready) begin
      pending[enc_idx] <= 1'b0;
      rem_q            <= rem_q - REM_ONE;
    end
  end

  assign remaining = rem_q;

endmodule

// File: tb/tb_reg_mask_encoder.sv
// Scoreboard bench for reg_mask_encoder; honours REG_MASK_ENC_MSB_FIRST_EN.
module tb_reg_mask_encoder;

  typedef struct packed {
    logic [4:0] idx;
    logic       last;
    logic [5:0] rem;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] mask_in;
  logic        mask_valid;
  logic        mask_ready;
  logic [4:0]  idx_out;
  logic        idx_valid;
  logic        idx_ready;
  logic        idx_last;
  logic [5:0]  remaining;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   valid_cnt = 0;
  exp_t sb[$];

  reg_mask_encoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mask_in    (mask_in),
    .mask_valid (mask_valid),
    .mask_ready (mask_ready),
    .idx_out    (idx_out),
    .idx_valid  (idx_valid),
    .idx_ready  (idx_ready),
    .idx_last   (idx_last),
    .remaining  (remaining)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected drain order, independent of the DUT's encoder
  task automatic push_expect(input logic [31:0] m);
    int n;
    int k;
    exp_t e;
    n = $countones(m);
    k = 0;
`ifdef REG_MASK_ENC_MSB_FIRST_EN
    for (int i = 31; i >= 0; i--) begin
`else
    for (int i = 0; i < 32; i++) begin
`endif
      if (m[i]) begin
        e.idx  = 5'(i);
        e.last = (k == n - 1);
        e.rem  = 6'(n - k);
        sb.push_back(e);
        k++;
      end
    end
  endtask

  // Offer a mask until accepted; acc = cycle number of the accepting edge
  task automatic send_mask(input logic [31:0] m, output int acc);
    int n;
    mask_in    = m;
    mask_valid = 1'b1;
    n = 0;
    while (!mask_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", {31'b0, mask_ready}, 32'd1);
    push_expect(m);
    @(posedge clk);
    acc = cyc;
    #1;
    mask_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mask_ready && n < 200);
    chk({tag, "_idle"}, {31'b0, mask_ready}, 32'd1);
    chk({tag, "_sb_left"}, sb.size(), 32'd0);
  endtask

  // Monitor: compare every valid cycle to the scoreboard head; pop on handshake
  always @(negedge clk) begin
    if (rst_n && idx_valid) begin
      valid_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_valid", {31'b0, idx_valid}, 32'd0);
      end else begin
        chk("idx", {27'b0, idx_out}, {27'b0, sb[0].idx});
        chk("last", {31'b0, idx_last}, {31'b0, sb[0].last});
        chk("remaining", {26'b0, remaining}, {26'b0, sb[0].rem});
        if (idx_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int a1;
    int rel;
    rst_n      = 1'b0;
    mask_valid = 1'b0;
    mask_in    = '0;
    idx_ready  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mask_ready", {31'b0, mask_ready}, 32'd1);
    chk("rst_idx_valid", {31'b0, idx_valid}, 32'd0);
    chk("rst_idx_out", {27'b0, idx_out}, 32'd0);
    chk("rst_idx_last", {31'b0, idx_last}, 32'd0);
    chk("rst_remaining", {26'b0, remaining}, 32'd0);
    rst_n = 1'b1;
    rel = cyc;

    // Single-bit mask: first edge after release accepts, one index out
    send_mask(32'h0000_0001, a0);
    chk("release_first_edge", a0, rel);
    @(negedge clk);
    chk("t1_valid", {31'b0, idx_valid}, 32'd1);
    @(negedge clk);
    chk("t1_done_valid", {31'b0, idx_valid}, 32'd0);
    chk("t1_done_ready", {31'b0, mask_ready}, 32'd1);

    // Three sparse bits including both ends
    send_mask(32'h8000_0401, a0);
    valid_cnt = 0;
    wait_idle("sparse");
    chk("sparse_cycles", valid_cnt, 32'd3);

    // Full mask with consumer stalling every other cycle
    send_mask(32'hFFFF_FFFF, a0);
    valid_cnt = 0;
    idx_ready = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk);
      #1 idx_ready = ~idx_ready;
    end
    idx_ready = 1'b1;
    @(negedge clk);
    chk("full_cycles", valid_cnt, 32'd64);
    chk("full_remaining", {26'b0, remaining}, 32'd0);
    chk("full_idle", {31'b0, idx_valid}, 32'd0);
    chk("full_sb_left", sb.size(), 32'd0);

    // Empty mask stays idle; next mask accepted on the following edge
    send_mask(32'h0000_0000, a0);
    chk("zero_ready", {31'b0, mask_ready}, 32'd1);
    chk("zero_valid", {31'b0, idx_valid}, 32'd0);
    send_mask(32'h0000_0030, a1);
    chk("zero_next_accept", a1 - a0, 32'd1);
    wait_idle("after_zero");

    // Reset in the middle of a drain
    send_mask(32'h0000_00F0, a0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_valid", {31'b0, idx_valid}, 32'd0);
    chk("mid_rst_ready", {31'b0, mask_ready}, 32'd1);
    chk("mid_rst_idx", {27'b0, idx_out}, 32'd0);
    chk("mid_rst_last", {31'b0, idx_last}, 32'd0);
    chk("mid_rst_remaining", {26'b0, remaining}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rel = cyc;
    send_mask(32'h0000_0002, a0);
    chk("post_rst_first_edge", a0, rel);
    valid_cnt = 0;
    wait_idle("post_rst");
    chk("post_rst_cycles", valid_cnt, 32'd1);

    // Second mask held while the first drains
    send_mask(32'h0000_0003, a0);
    send_mask(32'h0000_0100, a1);
    chk("b2b_accept_gap", a1 - a0, 32'd3);
    wait_idle("b2b");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
